// File: rtl/xbus_pkg.sv
// xbus_pkg: shared xbus widths, master ids and request bundle
package xbus_pkg;
  localparam int XBUS_AW = 32;
  localparam int XBUS_DW = 32;
  localparam int XBUS_BEW = 4;
  typedef enum logic {M_IFETCH = 1'b0, M_LSU = 1'b1} xbus_mid_t;
  typedef struct packed {
    logic                we;
    logic [XBUS_BEW-1:0] be;
    logic [XBUS_AW-1:0]  addr;
    logic [XBUS_DW-1:0]  wdata;
  } xbus_req_t;
endpackage

// File: rtl/xbus_rr_pick.sv
// xbus_rr_pick: 2-way round-robin/fixed-priority winner select (clk, rst, req0, req1 -> winner) with last_gnt state
module xbus_rr_pick
  import xbus_pkg::*;
#(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      req0,
  input  logic      req1,
  output xbus_mid_t winner
);
  xbus_mid_t last_gnt;
  always_comb winner = (req0 && req1) ? ((FIXED_PRIO || last_gnt == M_IFETCH) ? M_LSU : M_IFETCH)
                                      : (req1 ? M_LSU : M_IFETCH);
  always_ff @(posedge clk)
    if (rst) last_gnt <= M_LSU;
    else if (req0 || req1) last_gnt <= winner;
endmodule

// File: rtl/xbus_arbiter.sv
// xbus_arbiter: shares one fixed-latency slave between m0 (ifetch) and m1 (lsu); m*_req/we/be/addr/wdata in, m*_gnt/rvalid/rdata out, s_* slave side
module xbus_arbiter
  import xbus_pkg::*;
#(
  parameter int RD_LATENCY = 1,
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                m0_req,
  input  logic                m0_we,
  input  logic [XBUS_BEW-1:0] m0_be,
  input  logic [XBUS_AW-1:0]  m0_addr,
  input  logic [XBUS_DW-1:0]  m0_wdata,
  output logic                m0_gnt,
  output logic                m0_rvalid,
  output logic [XBUS_DW-1:0]  m0_rdata,
  input  logic                m1_req,
  input  logic                m1_we,
  input  logic [XBUS_BEW-1:0] m1_be,
  input  logic [XBUS_AW-1:0]  m1_addr,
  input  logic [XBUS_DW-1:0]  m1_wdata,
  output logic                m1_gnt,
  output logic                m1_rvalid,
  output logic [XBUS_DW-1:0]  m1_rdata,
  output logic                s_cs,
  output logic                s_we,
  output logic [XBUS_BEW-1:0] s_be,
  output logic [XBUS_AW-1:0]  s_addr,
  output logic [XBUS_DW-1:0]  s_wdata,
  input  logic [XBUS_DW-1:0]  s_rdata
);
  xbus_mid_t winner;
  xbus_req_t rs;
  logic rd_acc;
  logic [RD_LATENCY-1:0] tag_v, tag_id;
  xbus_rr_pick #(.FIXED_PRIO(FIXED_PRIO)) u_pick (
    .clk(clk),
    .rst(rst),
    .req0(m0_req),
    .req1(m1_req),
    .winner(winner)
  );
  always_comb begin
    m0_gnt = winner == M_IFETCH && m0_req && !rst;
    m1_gnt = winner == M_LSU && m1_req && !rst;
    rs = winner == M_LSU ? xbus_req_t'{m1_we, m1_be, m1_addr, m1_wdata}
                         : xbus_req_t'{m0_we, m0_be, m0_addr, m0_wdata};
    s_cs = m0_gnt | m1_gnt;
    s_we = rs.we;
    s_be = rs.be;
    s_addr = rs.addr;
    s_wdata = rs.wdata;
    rd_acc = s_cs && !rs.we;
    m0_rvalid = !rst && tag_v[RD_LATENCY-1] && !tag_id[RD_LATENCY-1];
    m1_rvalid = !rst && tag_v[RD_LATENCY-1] && tag_id[RD_LATENCY-1];
    m0_rdata = s_rdata;
    m1_rdata = s_rdata;
  end
  always_ff @(posedge clk)
    if (rst) tag_v <= '0;
    else begin
      tag_v <= RD_LATENCY'({tag_v, rd_acc});
      tag_id <= RD_LATENCY'({tag_id, winner == M_LSU});
    end
endmodule

// File: tb/tb_xbus_arbiter.sv
// tb_xbus_arbiter: scoreboard bench for two arbiter configs (lat1/round-robin, lat3/fixed-priority)
module tb_xbus_arbiter;
  localparam int LAT0 = 1;
  localparam int LAT1 = 3;
  localparam bit PRI0 = 1'b0;
  localparam bit PRI1 = 1'b1;
  typedef struct {
    int          due;
    logic        id;
    logic [31:0] data;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  logic m_req[2], m_we[2];
  logic [3:0] m_be[2];
  logic [31:0] m_addr[2], m_wdata[2];
  logic m0_gnt[2], m1_gnt[2], m0_rvalid[2], m1_rvalid[2], s_cs[2], s_we[2];
  logic [3:0] s_be[2];
  logic [31:0] s_addr[2], s_wdata[2], s_rdata[2], m0_rdata[2], m1_rdata[2];
  logic [31:0] sp[2][4];
  exp_t q[2][$];
  logic last[2];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  xbus_arbiter #(.RD_LATENCY(LAT0), .FIXED_PRIO(PRI0)) dut0 (
    .clk(clk), .rst(rst),
    .m0_req(m_req[0]), .m0_we(m_we[0]), .m0_be(m_be[0]), .m0_addr(m_addr[0]), .m0_wdata(m_wdata[0]),
    .m0_gnt(m0_gnt[0]), .m0_rvalid(m0_rvalid[0]), .m0_rdata(m0_rdata[0]),
    .m1_req(m_req[1]), .m1_we(m_we[1]), .m1_be(m_be[1]), .m1_addr(m_addr[1]), .m1_wdata(m_wdata[1]),
    .m1_gnt(m1_gnt[0]), .m1_rvalid(m1_rvalid[0]), .m1_rdata(m1_rdata[0]),
    .s_cs(s_cs[0]), .s_we(s_we[0]), .s_be(s_be[0]), .s_addr(s_addr[0]), .s_wdata(s_wdata[0]),
    .s_rdata(s_rdata[0])
  );
  xbus_arbiter #(.RD_LATENCY(LAT1), .FIXED_PRIO(PRI1)) dut1 (
    .clk(clk), .rst(rst),
    .m0_req(m_req[0]), .m0_we(m_we[0]), .m0_be(m_be[0]), .m0_addr(m_addr[0]), .m0_wdata(m_wdata[0]),
    .m0_gnt(m0_gnt[1]), .m0_rvalid(m0_rvalid[1]), .m0_rdata(m0_rdata[1]),
    .m1_req(m_req[1]), .m1_we(m_we[1]), .m1_be(m_be[1]), .m1_addr(m_addr[1]), .m1_wdata(m_wdata[1]),
    .m1_gnt(m1_gnt[1]), .m1_rvalid(m1_rvalid[1]), .m1_rdata(m1_rdata[1]),
    .s_cs(s_cs[1]), .s_we(s_we[1]), .s_be(s_be[1]), .s_addr(s_addr[1]), .s_wdata(s_wdata[1]),
    .s_rdata(s_rdata[1])
  );
  function automatic logic [31:0] mem(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9bdf;
  endfunction
  always @(posedge clk)
    for (int k = 0; k < 2; k++) begin
      sp[k][0] <= mem(s_addr[k]);
      for (int i = 1; i < 4; i++) sp[k][i] <= sp[k][i-1];
    end
  assign s_rdata[0] = sp[0][LAT0-1];
  assign s_rdata[1] = sp[1][LAT1-1];
  task automatic chk(input bit ok, input string name, input int k, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s dut%0d cyc %0d: got %0h expected %0h", name, k, cyc, act, exp);
    end
  endtask
  always @(negedge clk) begin : model
    logic w, gr;
    logic [2:0] eg;
    for (int k = 0; k < 2; k++) begin
      w = 1'b0;
      gr = 1'b0;
      if (rst) begin
        last[k] = 1'b1;
        q[k].delete();
        eg = 3'b000;
      end else begin
        gr = m_req[0] | m_req[1];
        w = (m_req[0] && m_req[1]) ? ((k ? PRI1 : PRI0) ? 1'b1 : ~last[k]) : m_req[1];
        eg = {gr && !w, gr && w, gr};
        if (gr) begin
          last[k] = w;
          if (!m_we[w]) q[k].push_back('{cyc + (k ? LAT1 : LAT0), w, mem(m_addr[w])});
        end
      end
      chk({m0_gnt[k], m1_gnt[k], s_cs[k]} == eg, "gnt", k, {m0_gnt[k], m1_gnt[k], s_cs[k]}, eg);
      if (gr)
        chk({s_we[k], s_be[k], s_addr[k], s_wdata[k]} == {m_we[w], m_be[w], m_addr[w], m_wdata[w]}, "sfields", k,
            {s_we[k], s_be[k], s_addr[k], s_wdata[k]}, {m_we[w], m_be[w], m_addr[w], m_wdata[w]});
    end
  end
  always @(negedge clk) begin : monitor
    logic [1:0] rv;
    logic due;
    exp_t e;
    #1;
    for (int k = 0; k < 2; k++) begin
      rv = {m0_rvalid[k], m1_rvalid[k]};
      due = q[k].size() > 0 && q[k][0].due == cyc;
      if (rv != 2'b00 || due) begin
        if (!due) chk(1'b0, "unexpected_rvalid", k, rv, 2'b00);
        else begin
          e = q[k].pop_front();
          chk(rv == (e.id ? 2'b01 : 2'b10), "rvalid", k, rv, e.id ? 2'b01 : 2'b10);
          chk((e.id ? m1_rdata[k] : m0_rdata[k]) == e.data, "rdata", k, e.id ? m1_rdata[k] : m0_rdata[k], e.data);
        end
      end
    end
  end
  task automatic set(input int m, input logic req, input logic we, input logic [3:0] be, input logic [31:0] addr, input logic [31:0] wdata);
    m_req[m] = req;
    m_we[m] = we;
    m_be[m] = be;
    m_addr[m] = addr;
    m_wdata[m] = wdata;
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic idle();
    set(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    set(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
  endtask
  initial begin
    idle();
    tick(3);
    rst = 1'b0;
    tick(1);
    set(0, 1'b1, 1'b0, 4'hf, 32'h0000_0004, 32'h0);
    tick(1);
    idle();
    tick(5);
    for (int i = 0; i < 8; i++) begin
      set(0, 1'b1, 1'b0, 4'hf, 32'h100 + 32'(i * 4), 32'h0);
      set(1, 1'b1, 1'b0, 4'hf, 32'h200 + 32'(i * 4), 32'h0);
      tick(1);
    end
    idle();
    set(1, 1'b1, 1'b1, 4'b0011, 32'h10, 32'hdead_beef);
    tick(1);
    idle();
    tick(5);
    set(0, 1'b1, 1'b0, 4'hf, 32'h20, 32'h0);
    tick(1);
    set(0, 1'b1, 1'b0, 4'hf, 32'h24, 32'h0);
    tick(1);
    idle();
    set(1, 1'b1, 1'b0, 4'hf, 32'h28, 32'h0);
    tick(1);
    idle();
    tick(5);
    set(0, 1'b1, 1'b0, 4'hf, 32'h30, 32'h0);
    tick(1);
    idle();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set(0, 1'b1, 1'b0, 4'hf, 32'h400 + 32'(i * 4), 32'h0);
      set(1, 1'b1, 1'b0, 4'hf, 32'h500 + 32'(i * 4), 32'h0);
      tick(1);
    end
    for (int i = 0; i < 2000; i++) begin
      rst = $urandom_range(0, 199) == 0;
      for (int m = 0; m < 2; m++)
        set(m, $urandom_range(0, 9) < 6, $urandom_range(0, 9) < 3, 4'($urandom), $urandom, $urandom);
      tick(1);
    end
    rst = 1'b0;
    idle();
    tick(8);
    for (int k = 0; k < 2; k++) chk(q[k].size() == 0, "drain", k, q[k].size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/xbus_arbiter.md
Name: xbus_arbiter

Overview:
- Two-master, one-slave arbiter for the xbus.
- Shares a single slave (boot ROM or any slave with fixed read latency) between the instruction-fetch master (m0) and the load/store master (m1).
- Grants one request per cycle, forwards it to the slave, and tracks in-flight reads so each read's data returns only to its issuer, with a valid strobe.

Parameters:
- RD_LATENCY, 1, cycles from slave cs sample (read) to valid s_rdata; legal range 1..4.
- FIXED_PRIO, 0, 0 = round-robin between m0/m1; 1 = m1 always wins a tie.

Ports:
- clk  input  1  system clock, all state on posedge
- rst  input  1  synchronous reset, active-high
- m0_req  input  1  m0 request valid; held with stable fields until m0_gnt
- m0_we  input  1  m0 write enable
- m0_be  input  4  m0 byte enables
- m0_addr  input  32  m0 byte address
- m0_wdata  input  32  m0 write data
- m0_gnt  output  1  m0 request accepted this cycle
- m0_rvalid  output  1  m0 read data valid
- m0_rdata  output  32  m0 read data
- m1_req, m1_we, m1_be, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata: same as the m0 ports, for m1
- s_cs  output  1  slave chip select
- s_we  output  1  slave write enable
- s_be  output  4  slave byte enables
- s_addr  output  32  slave address
- s_wdata  output  32  slave write data
- s_rdata  input  32  slave read data, valid RD_LATENCY cycles after accepted read

Behaviour:
- Arbitration is combinational within the cycle; the grant select is registered state.
- Winner:
  - Only one master requesting: that master.
  - Both requesting, FIXED_PRIO=1: m1.
  - Both requesting, FIXED_PRIO=0: the master not recorded in last_gnt.
- last_gnt is updated on every accepted request. Reset value is m1, so m0 wins the first tie.
- mX_gnt = winner==X && mX_req && !rst. Exactly one gnt is high when any req is high. No gnt while rst.
- s_cs = m0_gnt | m1_gnt. s_we/s_be/s_addr/s_wdata are muxed from the winner.
  - When idle, these fields are driven from m0 and s_cs=0; slaves ignore them.
- Accepted read (gnt && !we):
  - A tag {valid=1, id} enters a RD_LATENCY-deep shift register.
  - When the tag exits the shift register, mID_rvalid=1 for exactly one cycle.
  - m0_rdata = m1_rdata = s_rdata, passed unconditionally; rvalid qualifies it.
  - Total latency: request cycle T -> rvalid at T+RD_LATENCY.
- Accepted write: no tag, no rvalid; completes at the grant cycle.
- Throughput: one accepted access per cycle. Back-to-back reads from alternating masters each return in order, one per cycle.
- A master may issue a new request in the cycle its rvalid fires, and may have up to RD_LATENCY reads outstanding.
- Round-robin with both masters requesting continuously gives a strict m0, m1, m0, m1 alternation. Neither master starves.
- Simultaneous tag exit and new grant: independent, both occur.
- Reset:
  - Clears the tag pipeline; in-flight reads are dropped, with no rvalid after reset.
  - last_gnt returns to m1.
  - All gnt/rvalid/s_cs are 0 during rst and in the first cycle after reset with no req.
- A master dropping req before gnt is legal: the request is withdrawn, with no side effect.

Decomposition:
- Package xbus_pkg holds:
  - XBUS_AW=32, XBUS_DW=32, XBUS_BEW=4
  - typedef xbus_mid_t (1-bit master id; M_IFETCH=0, M_LSU=1)
  - packed struct xbus_req_t {we, be, addr, wdata}
- Sub-module xbus_rr_pick handles the 2-way round-robin/fixed-priority selector and the last_gnt register.
- The tag shift register stays inline.

Test Plan:
- Single read, RD_LATENCY=1: m0 reads 0x0000_0004 at cycle T -> m0_gnt=1 at T, s_cs=1, s_addr=0x4; m0_rvalid=1 at T+1 with s_rdata (e.g. 0x0000_8067); m1_rvalid stays 0.
- Tie, round-robin: both req reads continuously from reset -> grants m0, m1, m0, m1; rvalids alternate m0, m1, ... one cycle later; each rdata matches its own address.
- FIXED_PRIO=1: both req for 3 cycles -> m1_gnt=1 for all 3, m0_gnt=0. After m1 drops req -> m0_gnt=1 next cycle.
- Write: m1 we=1, be=4'b0011, addr=0x10, wdata=0xDEADBEEF -> s_we=1 and fields forwarded in the grant cycle; no m1_rvalid ever follows.
- RD_LATENCY=3, pipelined: m0 reads at T, T+1, then m1 at T+2 -> rvalid m0 at T+3, T+4, m1 at T+5.
- Reset mid-flight: read granted at T, rst=1 at T+1 -> no rvalid at T+1 or later. After rst falls, the first tie grants m0.
